// File: rtl/int_sync_pkg.sv
// Shared sizing defaults and payload typedefs for the interrupt sync gateway/arbiter.
package int_sync_pkg;

  localparam int unsigned NSRC_DEFAULT = 4;
  localparam int unsigned IDW_DEFAULT  = 2;

  typedef logic [NSRC_DEFAULT-1:0] src_vec_t;
  typedef logic [IDW_DEFAULT-1:0]  src_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: lowest requesting index at or above ptr_i, else lowest overall.
module rr_arbiter
  import int_sync_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT,
  parameter int unsigned IDW  = IDW_DEFAULT
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            valid_c_o,
  output logic [IDW-1:0]  grant_c_o
);

  logic [NSRC-1:0] upper_req;
  logic [NSRC-1:0] pick_vec;

  // Requests at or above the pointer take priority over the wrapped-around ones
  always_comb begin
    upper_req = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      upper_req[i] = req_i[i] & (i >= 32'(ptr_i));
    end
    pick_vec = (|upper_req) ? upper_req : req_i;
  end

  // Lowest set bit of the chosen vector becomes the grant
  always_comb begin
    valid_c_o = |req_i;
    grant_c_o = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        grant_c_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/int_sync_gateway_arb.sv
// Level-interrupt gateway: latches pending sources, offers them round-robin,
// tracks in-flight claims until completion and drives a registered summary line.
module int_sync_gateway_arb
  import int_sync_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT,
  parameter int unsigned IDW  = IDW_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] auto_in,
  input  logic [NSRC-1:0] en,
  output logic            claim_valid,
  output logic [IDW-1:0]  claim_id,
  input  logic            claim_ready,
  input  logic            cmpl_valid,
  input  logic [IDW-1:0]  cmpl_id,
  output logic            auto_out_sync_0
);

  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] inflight_q, inflight_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            sync_q, sync_d;
  logic [NSRC-1:0] offer;
  logic            claim_fire;

  assign offer      = pending_q & en;
  assign claim_fire = claim_valid & claim_ready;

  rr_arbiter #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req_i     (offer),
    .ptr_i     (rr_ptr_q),
    .valid_c_o (claim_valid),
    .grant_c_o (claim_id)
  );

  // Next state: gateway sampling, completion, then claim (claim wins on a shared id)
  always_comb begin
    pending_d  = pending_q | (auto_in & ~inflight_q);
    inflight_d = inflight_q;
    rr_ptr_d   = rr_ptr_q;
    sync_d     = |offer;
    if (cmpl_valid && (32'(cmpl_id) < NSRC)) begin
      inflight_d[cmpl_id] = 1'b0;
    end
    if (claim_fire) begin
      pending_d[claim_id]  = 1'b0;
      inflight_d[claim_id] = 1'b1;
      rr_ptr_d = (32'(claim_id) == NSRC - 1) ? '0 : claim_id + IDW'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q  <= '0;
      inflight_q <= '0;
      rr_ptr_q   <= '0;
      sync_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
      sync_q     <= sync_d;
    end
  end

  assign auto_out_sync_0 = sync_q;

endmodule

// File: doc/int_sync_gateway_arb.md
INT_SYNC_GATEWAY_ARB -- requirements
Module: int_sync_gateway_arb

Interface
REQ-001 SHALL take parameter NSRC, default 4: number of level-sensitive interrupt sources, 2..16.
REQ-002 SHALL take parameter IDW, default 2: source-id width, equal to clog2(NSRC).
REQ-003 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port auto_in, input, NSRC: level interrupt requests, already synchronised to clock.
REQ-006 SHALL have port en, input, NSRC: per-source enable mask.
REQ-007 SHALL have port claim_valid, output, 1: an enabled pending source is offered.
REQ-008 SHALL have port claim_id, output, IDW: id of the offered source; meaningful only while claim_valid=1.
REQ-009 SHALL have port claim_ready, input, 1: consumer accepts the offered source.
REQ-010 SHALL have port cmpl_valid, input, 1: completion strobe.
REQ-011 SHALL have port cmpl_id, input, IDW: id being completed.
REQ-012 SHALL have port auto_out_sync_0, output, 1: registered "any enabled pending" line toward the sync crossing.

Function
REQ-013 SHALL hold per-source state pending[i] and inflight[i]; idle = both 0.
REQ-014 SHALL set pending[i] at the clock edge where auto_in[i]=1 and inflight[i]=0, regardless of en[i].
REQ-015 SHALL make claim_valid a combinational function of registered state: claim_valid = |(pending & en).
REQ-016 SHALL select claim_id round-robin: first index at or above rr_ptr (wrapping) with pending&en set.
REQ-017 SHALL treat a claim handshake (claim_valid & claim_ready) as: pending[claim_id]<=0, inflight[claim_id]<=1, rr_ptr<=(claim_id+1) mod NSRC.
REQ-018 SHALL let claim_id change while unaccepted if pending or en changes; pending never clears except via handshake or reset.
REQ-019 SHALL clear inflight[cmpl_id] when cmpl_valid=1; SHALL ignore completion of a non-inflight id or an id >= NSRC.
REQ-020 SHALL let a claimed-and-completed source re-pend no earlier than the cycle after inflight clears (gateway samples registered inflight).
REQ-021 On completion of id k in the same cycle as a claim of id k, the claim SHALL win (k was not inflight; completion ignored).
REQ-022 SHALL keep pending[i] set when en[i] deasserts; source is only masked from arbitration and auto_out_sync_0.
REQ-023 SHALL register auto_out_sync_0 <= |(pending & en) each cycle: 1 cycle after claim_valid rises.
REQ-024 Latency: auto_in[i] rising at edge n -> pending[i]=1, claim_valid=1 after edge n; auto_out_sync_0=1 after edge n+1.
REQ-025 rr_ptr SHALL wrap NSRC-1 -> 0; with NSRC non-power-of-two it SHALL never hold values >= NSRC.

Reset
REQ-026 While reset=0 at a clock edge: pending=0, inflight=0, rr_ptr=0, auto_out_sync_0=0; claim_valid consequently 0.
REQ-027 Reset asserted mid-handshake SHALL discard the claim; inputs other than reset SHALL be ignored that cycle.
REQ-028 The first edge with reset=1 SHALL begin normal sampling of auto_in.

Structure
REQ-029 Package int_sync_pkg SHALL hold NSRC_DEFAULT, IDW_DEFAULT and typedefs src_vec_t (NSRC bits) and src_id_t (IDW bits).
REQ-030 Round-robin selection SHALL live in one combinational sub-module rr_arbiter (inputs request vector, pointer; outputs valid, grant id).
REQ-031 All state SHALL be within int_sync_gateway_arb; rr_arbiter SHALL hold no registers.

Verification
REQ-032 Reset: reset=0 for 2 cycles with auto_in=4'b1111, en=4'b1111 -> claim_valid=0, auto_out_sync_0=0 throughout; pending after release at next edge.
REQ-033 Single source: auto_in=4'b0100, en=4'b1111, claim_ready=1 -> claim_id=2 one cycle after rise; inflight[2]=1; no re-claim until cmpl_valid=1, cmpl_id=2, then re-claim 2 cycles later while auto_in[2] stays 1.
REQ-034 Round-robin: auto_in=4'b1111 held, claim_ready=1, immediate completion each claim -> ids granted 0,1,2,3,0.
REQ-035 Masking: pending[1] set, en=4'b1101 -> claim_valid=0, auto_out_sync_0=0; raise en[1] -> claim_valid=1, claim_id=1 same cycle, auto_out_sync_0=1 next cycle.
REQ-036 Corner: cmpl_valid=1 cmpl_id=3 with inflight=0 -> no state change; claim and completion of same id 0 in one cycle -> inflight[0]=1 after edge.
